// File: rtl/task_uart_pkg.sv
// task_uart_pkg: shared state encoding, frame constants and pending-frame record for the answer UART framer
package task_uart_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_PAYLOAD, ST_CSUM, ST_FLUSH} state_t;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int HEADER_BYTES = 9;
  typedef struct packed {
    logic [31:0] size;
    logic [31:0] latency;
    logic [31:0] words;
  } pend_t;
  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
    return w[8*i +: 8];
  endfunction
endpackage

// File: rtl/answer_word_fifo.sv
// answer_word_fifo: synchronous 32-bit word FIFO with registered read and full/empty flags
module answer_word_fifo #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        rd_en,
  output logic [31:0] rd_data,
  output logic        full,
  output logic        empty
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_wr, do_rd;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_rd = rd_en && !empty;
  // a pop in the same cycle frees the slot, so a write on full still lands
  assign do_wr = wr_en && (!full || do_rd);
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      rd_data <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) begin
        rp <= rp + 1'b1;
        rd_data <= mem[rp[AW-1:0]];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (do_wr) mem[wp[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/task_answer_uart_framer.sv
// task_answer_uart_framer: buffers answer words and emits sync/size/latency/payload/checksum byte frames
module task_answer_uart_framer
  import task_uart_pkg::*;
#(
  parameter int         FIFO_DEPTH = 256,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_answer_valid,
  input  logic [31:0] i_answer_data,
  input  logic        i_answer_last,
  input  logic [31:0] i_answer_size_in_bytes,
  input  logic [31:0] i_answer_latency,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_busy,
  output logic        o_err
);
  state_t state;
  pend_t pend;
  logic pend_valid, word_ok;
  logic [31:0] wcnt, idx, popped, fifo_data;
  logic [7:0] csum;
  logic [1:0] hsel;
  logic fifo_full, fifo_empty, fifo_rd;
  logic acc, hdr_done, pay_last, pop_try, can_pop, wr_drop, last_take, last_drop;
  answer_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (i_clk),
    .rst    (i_rst),
    .wr_en  (i_answer_valid),
    .wr_data(i_answer_data),
    .rd_en  (fifo_rd),
    .rd_data(fifo_data),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );
  // header bytes 1..4 and 5..8 both map to little-endian byte idx[1:0]-1
  assign hsel = idx[1:0] - 2'd1;
  assign o_tx_valid = (state == ST_HDR) || (state == ST_PAYLOAD) || (state == ST_CSUM);
  assign o_tx_data = (state == ST_HDR) ? ((idx == 32'd0) ? SYNC_BYTE :
                                          (idx < 32'd5) ? byte_of(pend.size, hsel) :
                                          byte_of(pend.latency, hsel)) :
                     (state == ST_PAYLOAD) ? (word_ok ? byte_of(fifo_data, idx[1:0]) : 8'h00) :
                     (state == ST_CSUM) ? csum : 8'h00;
  assign o_busy = pend_valid || (state != ST_IDLE);
  assign acc = o_tx_valid && i_tx_ready;
  assign hdr_done = (state == ST_HDR) && acc && (idx == HEADER_BYTES - 1);
  assign pay_last = (state == ST_PAYLOAD) && acc && (idx == pend.size - 32'd1);
  // the registered FIFO read is issued with the byte before a word boundary so the word is ready in time
  assign pop_try = (hdr_done && (pend.size != 32'd0)) ||
                   ((state == ST_PAYLOAD) && acc && !pay_last && (idx[1:0] == 2'd3));
  assign can_pop = (popped < pend.words) && !fifo_empty;
  assign fifo_rd = (pop_try || (state == ST_FLUSH)) && can_pop;
  assign wr_drop = i_answer_valid && fifo_full && !fifo_rd;
  assign last_take = i_answer_valid && i_answer_last && !pend_valid;
  assign last_drop = i_answer_valid && i_answer_last && pend_valid;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
      pend <= '0;
      pend_valid <= 1'b0;
      wcnt <= '0;
      idx <= '0;
      popped <= '0;
      csum <= 8'h00;
      word_ok <= 1'b0;
      o_err <= 1'b0;
    end else begin
      if (i_answer_valid) wcnt <= i_answer_last ? 32'd0 : wcnt + 32'd1;
      if (last_take) begin
        pend_valid <= 1'b1;
        pend <= '{size: i_answer_size_in_bytes, latency: i_answer_latency, words: wcnt + 32'd1};
      end
      if (wr_drop || last_drop || (pop_try && !can_pop)) o_err <= 1'b1;
      if (fifo_rd) popped <= popped + 32'd1;
      if (pop_try) word_ok <= can_pop;
      if (acc && ((state == ST_PAYLOAD) || ((state == ST_HDR) && (idx != 32'd0)))) csum <= csum ^ o_tx_data;
      case (state)
        ST_IDLE: if (pend_valid) begin
          state <= ST_HDR;
          idx <= '0;
          popped <= '0;
          csum <= 8'h00;
        end
        ST_HDR: if (acc) begin
          idx <= hdr_done ? 32'd0 : idx + 32'd1;
          if (hdr_done) state <= (pend.size == 32'd0) ? ST_CSUM : ST_PAYLOAD;
        end
        ST_PAYLOAD: if (acc) begin
          if (pay_last) state <= ST_CSUM;
          else idx <= idx + 32'd1;
        end
        ST_CSUM: if (acc) state <= ST_FLUSH;
        ST_FLUSH: if (!can_pop) begin
          state <= ST_IDLE;
          pend_valid <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_task_answer_uart_framer.sv
// tb_task_answer_uart_framer: directed frame checks for the answer UART framer
module tb_task_answer_uart_framer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic av, al, ready, tx_valid, busy, err;
  logic [31:0] ad, asz, alat;
  logic [7:0] tx_data;
  logic av4, al4, ready4, tx_valid4, busy4, err4;
  logic [31:0] ad4;
  logic [7:0] tx_data4;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  task_answer_uart_framer dut (
    .i_clk(clk), .i_rst(rst),
    .i_answer_valid(av), .i_answer_data(ad), .i_answer_last(al),
    .i_answer_size_in_bytes(asz), .i_answer_latency(alat),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(ready),
    .o_busy(busy), .o_err(err)
  );

  task_answer_uart_framer #(.FIFO_DEPTH(4)) dut4 (
    .i_clk(clk), .i_rst(rst),
    .i_answer_valid(av4), .i_answer_data(ad4), .i_answer_last(al4),
    .i_answer_size_in_bytes(32'd20), .i_answer_latency(32'd0),
    .o_tx_data(tx_data4), .o_tx_valid(tx_valid4), .i_tx_ready(ready4),
    .o_busy(busy4), .o_err(err4)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; av = 1'b0; al = 1'b0; ad = '0; asz = '0; alat = '0; ready = 1'b0;
    av4 = 1'b0; al4 = 1'b0; ad4 = '0; ready4 = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic build(input logic [31:0] size, input logic [31:0] lat, input int nw,
                       input logic [31:0] w0, input logic [31:0] w1);
    logic [7:0] cs;
    logic [31:0] w;
    exp_q.delete();
    exp_q.push_back(8'hA5);
    for (int i = 0; i < 4; i++) exp_q.push_back(size[8*i +: 8]);
    for (int i = 0; i < 4; i++) exp_q.push_back(lat[8*i +: 8]);
    for (int i = 0; i < int'(size); i++) begin
      w = (i / 4 == 0) ? w0 : w1;
      exp_q.push_back((i / 4 < nw) ? w[8*(i%4) +: 8] : 8'h00);
    end
    cs = 8'h00;
    for (int i = 1; i < exp_q.size(); i++) cs = cs ^ exp_q[i];
    exp_q.push_back(cs);
  endtask

  task automatic send(input int nw, input logic [31:0] w0, input logic [31:0] w1,
                      input logic [31:0] size, input logic [31:0] lat);
    for (int i = 0; i < nw; i++) begin
      @(negedge clk);
      av = 1'b1; ad = (i == 0) ? w0 : w1; al = (i == nw - 1); asz = size; alat = lat;
    end
    @(negedge clk);
    av = 1'b0; al = 1'b0;
  endtask

  task automatic collect(input int n, input bit toggle);
    int cyc;
    bit stalled;
    logic [7:0] held;
    cyc = 0; stalled = 0; held = 8'h00;
    got_q.delete();
    while (got_q.size() < n && cyc < 3000) begin
      if (stalled) begin
        checks++;
        if (!tx_valid || tx_data !== held) begin
          failures++;
          $display("FAIL stall_hold: valid=%0b data=%02h required valid=1 data=%02h", tx_valid, tx_data, held);
        end
      end
      ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (tx_valid && ready) got_q.push_back(tx_data);
      stalled = tx_valid && !ready;
      held = tx_data;
      @(negedge clk);
      cyc++;
    end
    ready = 1'b0;
    if (got_q.size() < n) begin
      checks++; failures++;
      $display("FAIL collect_timeout: got %0d bytes required %0d", got_q.size(), n);
    end
  endtask

  task automatic compare_frame(input string name);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s_len: got %0d required %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL %s_byte%0d: got %02h required %02h", name, i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0 || tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle: busy=%0b valid=%0b required 0 0", name, busy, tx_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({tx_valid, tx_data, busy, err} !== 11'b0) begin
      failures++;
      $display("FAIL reset_state: valid=%0b data=%02h busy=%0b err=%0b required all 0", tx_valid, tx_data, busy, err);
    end
    checks++;
    if ({tx_valid4, tx_data4, busy4, err4} !== 11'b0) begin
      failures++;
      $display("FAIL reset_state4: valid=%0b data=%02h busy=%0b err=%0b required all 0", tx_valid4, tx_data4, busy4, err4);
    end
  endtask

  task automatic test_basic();
    int n;
    do_reset();
    build(32'd5, 32'h10, 2, 32'h44332211, 32'h00000055);
    send(2, 32'h44332211, 32'h00000055, 32'd5, 32'h10);
    n = 0;
    while (!tx_valid && n < 2) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
      failures++;
      $display("FAIL basic_latency: valid=%0b data=%02h required 1 a5", tx_valid, tx_data);
    end
    collect(exp_q.size(), 1'b0);
    compare_frame("basic");
    wait_idle("basic");
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL basic_err: got %0b required 0", err);
    end
  endtask

  task automatic test_stall();
    do_reset();
    build(32'd5, 32'h10, 2, 32'h44332211, 32'h00000055);
    send(2, 32'h44332211, 32'h00000055, 32'd5, 32'h10);
    collect(exp_q.size(), 1'b1);
    compare_frame("stall");
    wait_idle("stall");
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL stall_err: got %0b required 0", err);
    end
  endtask

  task automatic test_zero_size();
    do_reset();
    build(32'd0, 32'd0, 1, 32'hCAFEF00D, 32'd0);
    send(1, 32'hCAFEF00D, 32'd0, 32'd0, 32'd0);
    collect(exp_q.size(), 1'b0);
    compare_frame("zero");
    wait_idle("zero");
    checks++;
    if (dut.u_fifo.empty !== 1'b1) begin
      failures++;
      $display("FAIL zero_fifo_empty: got %0b required 1", dut.u_fifo.empty);
    end
    build(32'd2, 32'd1, 1, 32'h00007766, 32'd0);
    send(1, 32'h00007766, 32'd0, 32'd2, 32'd1);
    collect(exp_q.size(), 1'b0);
    compare_frame("after_flush");
    wait_idle("after_flush");
  endtask

  task automatic test_short_payload();
    do_reset();
    build(32'd8, 32'h20, 1, 32'hDDCCBBAA, 32'd0);
    send(1, 32'hDDCCBBAA, 32'd0, 32'd8, 32'h20);
    collect(exp_q.size(), 1'b0);
    compare_frame("short");
    wait_idle("short");
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL short_err: got %0b required 1", err);
    end
  endtask

  task automatic test_pending_overflow();
    int n;
    do_reset();
    build(32'd4, 32'd2, 1, 32'h04030201, 32'd0);
    send(1, 32'h04030201, 32'd0, 32'd4, 32'd2);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL pend_err_before: got %0b required 0", err);
    end
    send(1, 32'h0000BEEF, 32'd0, 32'd2, 32'd0);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL pend_err_after: got %0b required 1", err);
    end
    collect(exp_q.size(), 1'b0);
    compare_frame("pend");
    wait_idle("pend");
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (tx_valid) n++;
    end
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL pend_no_second_frame: valid cycles %0d required 0", n);
    end
  endtask

  task automatic test_fifo_full_and_reset();
    int n;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 4) begin
        checks++;
        if (err4 !== 1'b0) begin
          failures++;
          $display("FAIL full4_err_at_4: got %0b required 0", err4);
        end
      end
      av4 = 1'b1; ad4 = 32'h100 + i; al4 = (i == 4);
    end
    @(negedge clk);
    av4 = 1'b0; al4 = 1'b0;
    checks++;
    if (err4 !== 1'b1 || busy4 !== 1'b1) begin
      failures++;
      $display("FAIL full4_drop: err=%0b busy=%0b required 1 1", err4, busy4);
    end
    n = 0;
    while (!tx_valid4 && n < 2) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (tx_valid4 !== 1'b1 || tx_data4 !== 8'hA5) begin
      failures++;
      $display("FAIL full4_sync: valid=%0b data=%02h required 1 a5", tx_valid4, tx_data4);
    end
    ready4 = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1; ready4 = 1'b0;
    @(negedge clk);
    checks++;
    if ({tx_valid4, tx_data4, busy4, err4} !== 11'b0) begin
      failures++;
      $display("FAIL midframe_reset: valid=%0b data=%02h busy=%0b err=%0b required all 0", tx_valid4, tx_data4, busy4, err4);
    end
    rst = 1'b0;
    ready4 = 1'b1;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (tx_valid4) n++;
    end
    ready4 = 1'b0;
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL midframe_abort: valid cycles %0d required 0", n);
    end
  endtask

  initial begin
    rst = 1'b1; av = 1'b0; al = 1'b0; ad = '0; asz = '0; alat = '0; ready = 1'b0;
    av4 = 1'b0; al4 = 1'b0; ad4 = '0; ready4 = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_zero_size();
    test_short_payload();
    test_pending_overflow();
    test_fifo_full_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
